// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU subsystem: the instruction field layout,
// the opcode encodings and the sequencer state encoding. The ROM, the ALU
// and the sequencer all import this package.
package cpu_pkg;

    // Instruction word and bus widths
    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 5;
    localparam int REG_W   = 3;
    localparam int OP_W    = 3;

    // Field bit positions inside an instruction word
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
    localparam logic [OP_W-1:0] OP_AND  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd7;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Opcode field of a raw instruction word
    function automatic logic [OP_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    // True when the word is a LOAD, which skips the ALU entirely
    function automatic logic is_load_word(input logic [INSTR_W-1:0] instr);
        return get_opcode(instr) == OP_LOAD;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction slicer: splits the held instruction
// register into register-file addresses, ALU opcode and the zero-extended
// immediate.
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int IMM_W  = 7,
    parameter int DATA_W = 8
) (
    input  logic [INSTR_W-1:0] ir,
    output logic [OP_W-1:0]    opcode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [DATA_W-1:0]  imm,
    output logic               is_load
);

    // Field extraction; the immediate overlaps rs2 and the low field by design
    always_comb begin
        opcode  = ir[OP_MSB:OP_LSB];
        rd      = ir[RD_MSB:RD_LSB];
        rs1     = ir[RS1_MSB:RS1_LSB];
        rs2     = ir[RS2_MSB:RS2_LSB];
        imm     = DATA_W'(ir[IMM_W-1:0]);
        is_load = (ir[OP_MSB:OP_LSB] == OP_LOAD);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller. Owns the program
// counter and the instruction register, drives the instruction ROM, and
// waits on the ALU done flag for multi-cycle operations.
//
// ALU handshake: alu_start is a one-cycle launch pulse on the first EXEC
// cycle; the sequencer stays in EXEC until it samples alu_done high, and a
// done seen in the same cycle as alu_start ends EXEC immediately. alu_done
// is ignored in every other state.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PROG_LEN = 9,
    parameter int IMM_W    = 7,
    parameter int DATA_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [REG_W-1:0]   rf_raddr_a,
    output logic [REG_W-1:0]   rf_raddr_b,
    output logic [OP_W-1:0]    alu_op,
    output logic               alu_start,
    input  logic               alu_done,
    output logic               rf_we,
    output logic [REG_W-1:0]   rf_waddr,
    output logic               rf_wsel,
    output logic [DATA_W-1:0]  imm,
    output logic               busy,
    output logic               halted
);

    // Address of the final instruction; WB at this pc halts instead of advancing
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    // Architectural state
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;

    // Registered strobes, computed from the next state so they line up with it
    logic rom_en_q, rom_en_d;
    logic alu_start_q, alu_start_d;
    logic rf_we_q, rf_we_d;
    logic busy_q, busy_d;
    logic halted_q, halted_d;

    // Decoded fields of the held instruction
    logic [OP_W-1:0]   dec_opcode;
    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_rs1;
    logic [REG_W-1:0]  dec_rs2;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_is_load;

    instr_decoder #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_decoder (
        .ir      (ir_q),
        .opcode  (dec_opcode),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm),
        .is_load (dec_is_load)
    );

    // Next-state, pc and ir update, plus the registered strobe values
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // ROM word is valid now, one cycle after the FETCH read
                ir_d    = rom_data;
                state_d = is_load_word(rom_data) ? ST_WB : ST_EXEC;
            end
            ST_EXEC: begin
                if (alu_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (pc_q == LAST_PC) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase

        rom_en_d    = (state_d == ST_FETCH);
        alu_start_d = (state_d == ST_EXEC) && (state_q != ST_EXEC);
        rf_we_d     = (state_d == ST_WB);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
        halted_d    = (state_d == ST_HALT);
    end

    // All sequencer flops, cleared by the synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            rom_en_q    <= 1'b0;
            alu_start_q <= 1'b0;
            rf_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rom_en_q    <= rom_en_d;
            alu_start_q <= alu_start_d;
            rf_we_q     <= rf_we_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    // Output drive: strobes from flops, field outputs as slices of ir
    always_comb begin
        rom_en     = rom_en_q;
        rom_addr   = pc_q;
        alu_start  = alu_start_q;
        rf_we      = rf_we_q;
        rf_wsel    = rf_we_q & dec_is_load;
        busy       = busy_q;
        halted     = halted_q;
        rf_raddr_a = dec_rs1;
        rf_raddr_b = dec_rs2;
        rf_waddr   = dec_rd;
        alu_op     = dec_opcode;
        imm        = dec_imm;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/decode/execute/writeback controller for the CPU subsystem. Drives the instruction ROM (5-bit address, 16-bit word, one-cycle synchronous read with enable). Slices each instruction into register-file and ALU controls, and handshakes with the ALU so multi-cycle ops such as multiply are waited on. Sits between the ROM, the register file and the ALU; owns the program counter.

Parameters:
PROG_LEN, 9, number of instructions executed before halting (address PROG_LEN-1 is the last); legal range 1..32
IMM_W, 7, immediate width taken from instr[IMM_W-1:0]
DATA_W, 8, width of the imm output; the immediate is zero-extended to this width (DATA_W >= IMM_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a run from address 0
rom_en  out  1  ROM read enable
rom_addr  out  5  ROM address (= pc)
rom_data  in  16  ROM output, valid the cycle after rom_en
rf_raddr_a  out  3  rs1 = ir[9:7]
rf_raddr_b  out  3  rs2 = ir[6:4]
alu_op  out  3  ir[15:13]
alu_start  out  1  one-cycle ALU launch pulse
alu_done  in  1  ALU result valid
rf_we  out  1  register-file write strobe
rf_waddr  out  3  rd = ir[12:10]
rf_wsel  out  1  0 = ALU result, 1 = imm
imm  out  DATA_W  zero-extended ir[IMM_W-1:0]
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT

Behaviour:
- Instruction format: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] low field.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 SHL, 110 SHR, 111 LOAD.
- States:
  - IDLE: entered on reset. Goes to FETCH on start.
  - FETCH: rom_en=1, rom_addr=pc. Always goes to DECODE.
  - DECODE: ir <= rom_data on exit. Goes to WB if the opcode is LOAD, else to EXEC.
  - EXEC: alu_start=1 on the first EXEC cycle only. Stays until alu_done=1, then goes to WB. alu_done sampled in the same cycle as alu_start counts, giving a single EXEC cycle.
  - WB: rf_we=1 for exactly one cycle; rf_wsel=1 for LOAD, 0 otherwise. At the WB edge: if pc == PROG_LEN-1, go to HALT and leave pc unchanged; else pc <= pc+1 and go to FETCH.
  - HALT: halted=1. start returns the block to FETCH with pc=0.
- rf_raddr_a/b, rf_waddr, alu_op and imm are combinational slices of ir and are held stable from DECODE exit until the next DECODE exit.
- Latency:
  - LOAD: 3 cycles (FETCH, DECODE, WB).
  - ALU op: 3 cycles plus EXEC length (minimum 4).
  - 9-instruction program with single-cycle ALU: 2×3 + 7×4 = 34 cycles from the first FETCH to HALT.
- Reset values: pc=0, ir=0, state=IDLE. All strobes 0, busy=0, halted=0. Since ir=0, all field outputs are 0.
- Boundary conditions:
  - start outside IDLE/HALT is ignored.
  - alu_done outside EXEC is ignored.
  - alu_done held high through several EXEC cycles produces one WB only.
  - rst mid-instruction aborts immediately: no rf_we is issued, pc returns to 0.
  - pc never wraps, because PROG_LEN ≤ 32.
  - rom_en is low in every state except FETCH.

Decomposition:
- cpu_pkg holds the opcode localparams (OP_ADD..OP_LOAD), the state encoding (IDLE, FETCH, DECODE, EXEC, WB, HALT) and the field bit positions. The ROM, ALU and this block all share it.
- One sub-module, instr_decoder: combinational, ir in; rd/rs1/rs2/opcode/imm/is_load out.

Test Plan:
- rst high 3 cycles, then low with no start → outputs at reset values, rom_en stays 0, busy=0 indefinitely.
- start with ROM word 0 = 111_010_000_000_0101 → rom_en at cycle 1, rom_addr=0. In WB: rf_we=1, rf_wsel=1, rf_waddr=2, imm=5. Next FETCH has rom_addr=1.
- ADD word 000_001_010_011_0000, alu_done tied high → alu_start one cycle, rf_raddr_a=2, rf_raddr_b=3, alu_op=0, then rf_we with rf_waddr=1, rf_wsel=0.
- MUL word 100_111_010_011_0000, alu_done asserted 4 cycles after alu_start → exactly one alu_start, EXEC lasts 5 cycles, single rf_we pulse.
- Full 9-word program, single-cycle ALU → halted rises 34 cycles after the first FETCH. Exactly 9 rf_we pulses, rf_waddr sequence 2,3,1,4,5,6,7,0,0. start in HALT restarts at rom_addr=0.
- rst asserted in EXEC of instruction 2 → next cycle state IDLE, pc=0, no rf_we. start then refetches address 0.
